// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU output path: serializer FSM encoding,
// data width and frame geometry.
package cpu_io_pkg;

    localparam int DATA_W        = 4;
    localparam int FRAME_BITS    = 6;
    localparam int LAST_DATA_IDX = DATA_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Serial line level driven while in a given state.
    function automatic logic line_level(input tx_state_e st, input logic data_bit);
        case (st)
            ST_START: line_level = 1'b0;
            ST_DATA:  line_level = data_bit;
            default:  line_level = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO holding CPU output writes until the serializer can take them.
// Head entry is readable combinationally so a pop can load the shifter directly.
module out_fifo
    import cpu_io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    // Full comes from the registered level, so a write while full is
    // dropped even if the same edge also pops.
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= push_data;
                end
            end
        end
    endgenerate

    assign head_data = mem_q[rd_ptr_q];
    assign level     = level_q;

endmodule

// File: rtl/cpu_out_serializer.sv
// Buffers CPU output writes and shifts each one out as a start/4-data/stop
// frame on a single idle-high line, back-to-back when the FIFO stays non-empty.
module cpu_out_serializer
    import cpu_io_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   out_valid,
    input  logic [DATA_W-1:0]      out_data,
    output logic                   out_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       IDX_LAST = 2'(LAST_DATA_IDX);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic              bit_done;

    out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (out_valid),
        .push_data (out_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign out_ready  = ~fifo_full;
    assign bit_done   = (cnt_q == CNT_LAST);
    assign overflow_d = overflow_q | (out_valid & fifo_full);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    cnt_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    // Chain straight into the next frame to avoid an idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_d   = line_level(state_d, shift_d[0]);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cpu_out_serializer.sv
// Scoreboard bench: a timeline model predicts accepted writes and frame start
// edges; a monitor decodes the tx line and checks status outputs every cycle.
module tb_cpu_out_serializer;

    localparam int DEPTH      = 4;
    localparam int CPB        = 4;
    localparam int FRAME_CLKS = 6 * CPB;
    localparam int LVL_W      = $clog2(DEPTH) + 1;

    logic             clk       = 1'b0;
    logic             reset     = 1'b0;
    logic             out_valid = 1'b0;
    logic [3:0]       out_data  = 4'h0;
    logic             out_ready;
    logic             tx;
    logic             busy;
    logic             overflow;
    logic [LVL_W-1:0] level;

    cpu_out_serializer #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        int         pop_edge;
    } frame_t;

    logic [3:0] model_fifo[$];
    frame_t     sb[$];
    int         edge_cnt      = 0;
    int         next_pop_edge = 0;
    int         last_pop      = -100000;
    bit         model_ovf     = 1'b0;
    bit         in_frame      = 1'b0;
    int         frames_seen   = 0;
    int         checks        = 0;
    int         errors        = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)",
                     name, actual, expected, edge_cnt, $time);
        end
    endtask

    function automatic bit model_busy();
        return (edge_cnt >= last_pop) && (edge_cnt < last_pop + FRAME_CLKS);
    endfunction

    // Reference model: one frame occupies the line for FRAME_CLKS edges and the
    // next pop may happen on the edge that ends it; full is judged before the edge.
    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (!reset) begin
                model_fifo.delete();
                sb.delete();
                model_ovf     = 1'b0;
                next_pop_edge = 0;
                last_pop      = -100000;
            end else begin
                int     pre;
                frame_t f;
                pre = model_fifo.size();
                if (pre > 0 && edge_cnt >= next_pop_edge) begin
                    f.data        = model_fifo.pop_front();
                    f.pop_edge    = edge_cnt;
                    sb.push_back(f);
                    next_pop_edge = edge_cnt + FRAME_CLKS;
                    last_pop      = edge_cnt;
                end
                if (out_valid) begin
                    if (pre < DEPTH) model_fifo.push_back(out_data);
                    else model_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor: status outputs every cycle, tx decoded against scoreboard frames.
    initial begin
        frame_t     cur;
        int         pos;
        int         bad;
        int         b;
        logic       exp_bit;
        logic [5:0] sampled;
        pos     = 0;
        bad     = 0;
        sampled = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_frame = 1'b0;
                continue;
            end
            check("level", int'(level), model_fifo.size());
            check("out_ready", int'(out_ready), int'(model_fifo.size() < DEPTH));
            check("overflow", int'(overflow), int'(model_ovf));
            check("busy", int'(busy), int'(model_busy()));
            if (!in_frame) begin
                if (sb.size() > 0) begin
                    cur      = sb.pop_front();
                    check("start_bit", int'(tx), 0);
                    in_frame = 1'b1;
                    pos      = 1;
                    bad      = 0;
                    sampled  = '0;
                end else begin
                    check("idle_tx", int'(tx), 1);
                end
            end else begin
                b = pos / CPB;
                if (b == 0) exp_bit = 1'b0;
                else if (b == 5) exp_bit = 1'b1;
                else exp_bit = cur.data[b-1];
                if (tx !== exp_bit) bad++;
                if ((pos % CPB) == (CPB / 2)) sampled[b] = tx;
                pos++;
                if (pos == FRAME_CLKS) begin
                    check("frame_data", int'(sampled[4:1]), int'(cur.data));
                    check("frame_shape", bad, 0);
                    check("frame_stop", int'(sampled[5]), 1);
                    $display("frame %0d: data=%h popped at edge %0d, bad cycles %0d",
                             frames_seen, sampled[4:1], cur.pop_edge, bad);
                    frames_seen++;
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic write(input logic [3:0] v);
        out_valid = 1'b1;
        out_data  = v;
        @(negedge clk);
        out_valid = 1'b0;
        out_data  = 4'($urandom_range(0, 15));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((model_fifo.size() != 0 || sb.size() != 0 || in_frame || model_busy())
               && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s: drain timeout, got %0d cycles required < 2000", name, n);
        end
        idle(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        out_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_out_ready", int'(out_ready), 1);
        check("rst_overflow", int'(overflow), 0);
        check("rst_level", int'(level), 0);
        reset = 1'b1;
        idle(2);

        write(4'b1010);
        wait_quiet("single_drain");

        for (int i = 1; i <= 6; i++) write(4'(i));
        check("burst_overflow", int'(overflow), 1);
        wait_quiet("burst_drain");

        write(4'hF);
        write(4'h0);
        wait_quiet("b2b_drain");

        // Reset lands inside the second data bit (bit 1 of 4'h5 is 0 on the line).
        write(4'h5);
        idle(2 * CPB + 2);
        check("pre_reset_tx", int'(tx), 0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_tx", int'(tx), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_level", int'(level), 0);
        check("midrst_overflow", int'(overflow), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(2);
        write(4'h3);
        wait_quiet("post_reset_drain");

        // Push coincides with the STOP->START pop while two entries are queued.
        write(4'h1);
        write(4'h2);
        write(4'h3);
        idle(FRAME_CLKS - 2);
        check("simul_level_before", int'(level), 2);
        write(4'h4);
        check("simul_level_after", int'(level), 2);
        wait_quiet("simul_drain");

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 99) < 70) write(4'($urandom_range(0, 15)));
            else idle(1);
        end
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 12) write(4'($urandom_range(0, 15)));
            else idle(1);
        end
        wait_quiet("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_out_serializer.md
# cpu_out_serializer

Downstream consumer of the 4-bit CPU's `output_data` port. Each CPU output write is buffered in a small FIFO and shifted out on a single-wire serial line, so bursts of writes are not lost while a frame is in flight. The CPU keeps executing at full rate. The block adds no back-pressure to the CPU beyond the `out_ready` and `overflow` indications.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Must be a power of two and ≥ 2.
- `CLKS_PER_BIT`, 4: clock cycles per serial bit. Must be ≥ 1.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `out_valid`  in  1  CPU output-write strobe, one value per high cycle.
- `out_data`  in  4  value written by the CPU (its `output_data`).
- `out_ready`  out  1  high when the FIFO is not full; a write is accepted only when `out_valid & out_ready`.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is being shifted.
- `overflow`  out  1  sticky; set by a write attempted while full.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
Reset values:
- `reset` low forces, asynchronously: `tx`=1, `busy`=0, `overflow`=0, `level`=0, `out_ready`=1, FSM=IDLE. FIFO contents are discarded.

Frame format: 6 bits in this order.
- 1 start bit (0).
- `out_data[0]` through `out_data[3]`, LSB first.
- 1 stop bit (1).
- Each bit is held exactly `CLKS_PER_BIT` cycles.

FSM states: IDLE, START, DATA, STOP.
- IDLE: `tx`=1, `busy`=0. If `level`>0, pop the head into the shift register and go to START.
- START: `tx`=0. After `CLKS_PER_BIT` cycles, go to DATA with bit index 0.
- DATA: `tx`=shift[0]. Every `CLKS_PER_BIT` cycles, shift right and increment the index. After index 3 completes, go to STOP.
- STOP: `tx`=1. On its last cycle: if `level`>0, pop and go directly to START (back-to-back frames); otherwise go to IDLE.
- `busy`=1 in START, DATA and STOP.

FIFO rules:
- Push and pop in the same cycle are allowed; `level` is then unchanged.
- A write while full (`level`==DEPTH) is dropped and sets `overflow`, even if a pop happens on the same edge (`out_ready` is registered-full based).
- `overflow` clears only on reset.
- Read and write pointers wrap modulo DEPTH. `level` counts 0..DEPTH.
- A pop never occurs when empty.

## Timing
- A write accepted on edge E0 into an empty, idle block: `level`=1 after E0; the pop occurs at E1; `tx` falls after E1.
- Write-to-start-bit latency is therefore 2 edges.
- Frame length is exactly 6×`CLKS_PER_BIT` cycles. With back-to-back frames, consecutive start bits are exactly 6×`CLKS_PER_BIT` cycles apart, with no idle gap.
- `out_ready` reflects `level` after the previous edge and is combinational from registered state only.
- `tx`, `busy`, `overflow` and `level` are registered outputs.
- Reset mid-frame: the frame is truncated. `tx` returns to 1 immediately, and nothing resumes after reset release.

## Structure
- Shared package `cpu_io_pkg`:
  - FSM state encoding (IDLE/START/DATA/STOP).
  - `DATA_W`=4, `FRAME_BITS`=6.
- Sub-module `out_fifo`: synchronous FIFO (DEPTH×4). Exposes push, pop, full, empty and level.
- Top level: FSM, bit-period counter, bit index, shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `DEPTH`=4.
- **Reset:** hold `reset` low 3 cycles → `tx`=1, `busy`=0, `out_ready`=1, `overflow`=0, `level`=0.
- **Single write:** write 4'b1010 at E0 → after E1, `tx` sequence is 0,0,1,0,1,1 (4 cycles each); `busy` high for 24 cycles; then idle.
- **Burst with overflow:** writes 1,2,3,4,5,6 on E0–E5 → values 1–5 accepted; `level` reaches 4 after E4; write 6 dropped with `overflow`=1. Five frames go out back-to-back; start bits 24 cycles apart.
- **Back-to-back spacing:** write 4'hF then 4'h0 on consecutive edges → second start bit begins exactly 24 cycles after the first; no idle-high gap beyond the stop bit.
- **Reset mid-frame:** assert `reset` during the second data bit → `tx`=1 asynchronously and `level`=0. After release, writing 4'h3 produces a clean frame with the same timing as the single-write scenario.
- **Simultaneous push/pop:** `level`=2; write arrives on the same edge as the STOP→START pop → `level` stays 2 and the written value is transmitted in order.
